// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: sole APB master for the CoreUARTapb port (config, TX, RX).
// Define UART_ERRSTAT_EN to add a STATUS read after each RX byte and the rx_err output.
module uart_apb_sequencer #(
  parameter logic [12:0] BAUD_INIT  = 13'd1,
  parameter logic [2:0]  MODE_INIT  = 3'b001,
  parameter int unsigned HOLDOFF    = 2,
  parameter int unsigned PREADY_TMO = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cfg_load,
  input  logic [12:0] cfg_baud,
  input  logic [2:0]  cfg_mode,
  output logic        cfg_busy,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
`ifdef UART_ERRSTAT_EN
  output logic [2:0]  rx_err,
`endif
  output logic        apb_err,
  output logic [4:0]  M_PADDR,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [7:0]  M_PWDATA,
  input  logic [7:0]  M_PRDATA,
  input  logic        M_PREADY,
  input  logic        M_PSLVERR,
  input  logic        UART_TXRDY,
  input  logic        UART_RXRDY
);

  localparam int TW = $clog2(PREADY_TMO + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREADY_TMO - 1);
  localparam logic [HW-1:0] HOLD_RLD = HW'(HOLDOFF);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG1, S_CFG2, S_TXW, S_RXR, S_STS
  } state_e;

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] txh_q, txh_d, rxh_q, rxh_d;
  logic          txf_q, txf_d;
  logic [7:0]    txb_q, txb_d;
  logic          rxv_q, rxv_d;
  logic [7:0]    rxb_q, rxb_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;
  logic [12:0]   pbaud_q, pbaud_d, baud_q, baud_d;
  logic [2:0]    pmode_q, pmode_d, mode_q, mode_d;
  logic          last_tx_q, last_tx_d;
  logic [2:0]    rxe_q, rxe_d;
  logic          done, fail, tx_el, rx_el;

  assign cfg_busy = pend_q || state_q == S_CFG1 || state_q == S_CFG2;
  assign tx_ready = !txf_q && !cfg_busy;
  assign rx_data  = rxb_q;
  assign rx_valid = rxv_q;
  assign apb_err  = err_q;
`ifdef UART_ERRSTAT_EN
  assign rx_err   = rxe_q;
`endif
  assign M_PSEL    = state_q != S_IDLE;
  assign M_PENABLE = acc_q;

  assign done  = acc_q && (M_PREADY || tmo_q == TMO_LAST);
  assign fail  = !M_PREADY || M_PSLVERR;
  assign tx_el = txf_q && UART_TXRDY && txh_q == '0;
  assign rx_el = !rxv_q && UART_RXRDY && rxh_q == '0;

  always_comb begin
    M_PADDR  = 5'h00;
    M_PWRITE = 1'b0;
    M_PWDATA = 8'h00;
    unique case (state_q)
      S_CFG1: begin
        M_PADDR  = 5'h08;
        M_PWRITE = 1'b1;
        M_PWDATA = baud_q[7:0];
      end
      S_CFG2: begin
        M_PADDR  = 5'h0C;
        M_PWRITE = 1'b1;
        M_PWDATA = {baud_q[12:8], mode_q};
      end
      S_TXW: begin
        M_PWRITE = 1'b1;
        M_PWDATA = txb_q;
      end
      S_RXR:   M_PADDR = 5'h04;
      S_STS:   M_PADDR = 5'h10;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tmo_d     = tmo_q;
    txh_d     = (txh_q != '0) ? txh_q - HW'(1) : '0;
    rxh_d     = (rxh_q != '0) ? rxh_q - HW'(1) : '0;
    txf_d     = txf_q;
    txb_d     = txb_q;
    rxv_d     = rxv_q && !rx_ready;
    rxb_d     = rxb_q;
    err_d     = err_q;
    pend_d    = pend_q;
    pbaud_d   = pbaud_q;
    pmode_d   = pmode_q;
    baud_d    = baud_q;
    mode_d    = mode_q;
    last_tx_d = last_tx_q;
    rxe_d     = rxe_q;

    if (state_q == S_IDLE) begin
      if (pend_q) begin
        state_d = S_CFG1;
        pend_d  = 1'b0;
        baud_d  = pbaud_q;
        mode_d  = pmode_q;
      end else if (tx_el && (!rx_el || !last_tx_q)) begin
        state_d   = S_TXW;
        last_tx_d = 1'b1;
      end else if (rx_el) begin
        state_d   = S_RXR;
        last_tx_d = 1'b0;
      end
    end else if (!acc_q) begin
      acc_d = 1'b1;
      tmo_d = '0;
    end else if (!done) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      acc_d   = 1'b0;
      state_d = S_IDLE;
      err_d   = err_q || fail;
      unique case (state_q)
        S_CFG1: state_d = S_CFG2;
        S_TXW: begin
          txf_d = 1'b0;
          txh_d = HOLD_RLD;
        end
        S_RXR: begin
          if (!fail) rxb_d = M_PRDATA;
`ifdef UART_ERRSTAT_EN
          if (!fail) state_d = S_STS;
          else       rxh_d   = HOLD_RLD;
`else
          rxv_d = !fail;
          rxh_d = HOLD_RLD;
`endif
        end
        S_STS: begin
          rxh_d = HOLD_RLD;
          if (!fail) begin
            rxv_d = 1'b1;
            rxe_d = M_PRDATA[4:2];
          end
        end
        default: ;
      endcase
    end

    if (tx_valid && tx_ready) begin
      txf_d = 1'b1;
      txb_d = tx_data;
    end
    // A new request supersedes any pending one and clears the sticky error.
    if (cfg_load) begin
      pend_d  = 1'b1;
      pbaud_d = cfg_baud;
      pmode_d = cfg_mode;
      err_d   = acc_q && done && fail;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      acc_q     <= 1'b0;
      tmo_q     <= '0;
      txh_q     <= '0;
      rxh_q     <= '0;
      txf_q     <= 1'b0;
      txb_q     <= 8'h00;
      rxv_q     <= 1'b0;
      rxb_q     <= 8'h00;
      err_q     <= 1'b0;
      pend_q    <= 1'b1;
      pbaud_q   <= BAUD_INIT;
      pmode_q   <= MODE_INIT;
      baud_q    <= BAUD_INIT;
      mode_q    <= MODE_INIT;
      last_tx_q <= 1'b1;
      rxe_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      txh_q     <= txh_d;
      rxh_q     <= rxh_d;
      txf_q     <= txf_d;
      txb_q     <= txb_d;
      rxv_q     <= rxv_d;
      rxb_q     <= rxb_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      pbaud_q   <= pbaud_d;
      pmode_q   <= pmode_d;
      baud_q    <= baud_d;
      mode_q    <= mode_d;
      last_tx_q <= last_tx_d;
      rxe_q     <= rxe_d;
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed scenario bench for uart_apb_sequencer.
// Sequences config, TX, RX, arbitration, timeout, error and reset cases.
module tb_uart_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cfg_load;
  logic [12:0] cfg_baud;
  logic [2:0]  cfg_mode;
  logic        cfg_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
`ifdef UART_ERRSTAT_EN
  logic [2:0]  rx_err;
`endif
  logic        apb_err;
  logic [4:0]  M_PADDR;
  logic        M_PSEL;
  logic        M_PENABLE;
  logic        M_PWRITE;
  logic [7:0]  M_PWDATA;
  logic [7:0]  M_PRDATA;
  logic        M_PREADY;
  logic        M_PSLVERR;
  logic        UART_TXRDY;
  logic        UART_RXRDY;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  uart_apb_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cfg_load(cfg_load), .cfg_baud(cfg_baud),
    .cfg_mode(cfg_mode), .cfg_busy(cfg_busy),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
`ifdef UART_ERRSTAT_EN
    .rx_err(rx_err),
`endif
    .apb_err(apb_err), .M_PADDR(M_PADDR),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE),
    .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .M_PSLVERR(M_PSLVERR),
    .UART_TXRDY(UART_TXRDY), .UART_RXRDY(UART_RXRDY)
  );

  always #5 PCLK = ~PCLK;

  task automatic do_reset();
    PRESET = 1'b1;
    cfg_load = 1'b0; cfg_baud = '0; cfg_mode = '0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    M_PRDATA = '0; M_PREADY = 1'b1; M_PSLVERR = 1'b0;
    UART_TXRDY = 1'b0; UART_RXRDY = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic wait_psel(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge PCLK);
      if (M_PSEL) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cfg(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge PCLK);
      if (!cfg_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({M_PSEL, M_PENABLE} !== 2'b00)
      $display("FAIL rst_psel got %b exp 00", {M_PSEL, M_PENABLE});
    else pass_cnt++;
    chk_cnt++;
    if (cfg_busy !== 1'b1) $display("FAIL rst_busy got %b exp 1", cfg_busy);
    else pass_cnt++;
    chk_cnt++;
    if (tx_ready !== 1'b0) $display("FAIL rst_txrdy got %b exp 0", tx_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({rx_valid, apb_err} !== 2'b00)
      $display("FAIL rst_rxv_err got %b exp 00", {rx_valid, apb_err});
    else pass_cnt++;
    chk_cnt++;
    if (rx_data !== 8'h00) $display("FAIL rst_rxd got %h exp 00", rx_data);
    else pass_cnt++;
    PRESET = 1'b0;
  endtask

  task automatic test_cfg_init();
    bit ok;
    wait_psel(10, ok);
    chk_cnt++;
    if (!ok) $display("FAIL cfg1_wait got timeout exp psel");
    else pass_cnt++;
    chk_cnt++;
    if ({M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA} !== {1'b0, 1'b1, 5'h08, 8'h01})
      $display("FAIL cfg1_setup got %b %b %h %h exp 0 1 08 01",
               M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, M_PADDR, M_PWDATA} !== {2'b11, 5'h08, 8'h01})
      $display("FAIL cfg1_access got %b%b %h %h exp 11 08 01",
               M_PSEL, M_PENABLE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA} !== {3'b101, 5'h0C, 8'h01})
      $display("FAIL cfg2_setup got %b%b%b %h %h exp 101 0c 01",
               M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, M_PADDR} !== {2'b11, 5'h0C})
      $display("FAIL cfg2_access got %b%b %h exp 11 0c", M_PSEL, M_PENABLE, M_PADDR);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, cfg_busy, apb_err, tx_ready} !== 4'b0001)
      $display("FAIL cfg_done got %b%b%b%b exp 0001",
               M_PSEL, cfg_busy, apb_err, tx_ready);
    else pass_cnt++;
  endtask

  task automatic test_tx();
    bit ok;
    int n;
    UART_TXRDY = 1'b1;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    chk_cnt++;
    if ({M_PSEL, tx_ready} !== 2'b00)
      $display("FAIL tx_lat got %b%b exp 00", M_PSEL, tx_ready);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA} !== {3'b101, 5'h00, 8'h5A})
      $display("FAIL tx_setup got %b%b%b %h %h exp 101 00 5a",
               M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    UART_TXRDY = 1'b0;
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, M_PADDR, M_PWDATA} !== {2'b11, 5'h00, 8'h5A})
      $display("FAIL tx_access got %b%b %h %h exp 11 00 5a",
               M_PSEL, M_PENABLE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, tx_ready} !== 2'b01)
      $display("FAIL tx_done got %b%b exp 01", M_PSEL, tx_ready);
    else pass_cnt++;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (M_PSEL) n++;
    end
    chk_cnt++;
    if (n !== 0) $display("FAIL tx_wait_rdy got %0d exp 0", n);
    else pass_cnt++;
    UART_TXRDY = 1'b1;
    wait_psel(5, ok);
    chk_cnt++;
    if (!ok || M_PWDATA !== 8'hA5)
      $display("FAIL tx2_data got %b %h exp 1 a5", ok, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    @(negedge PCLK);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    chk_cnt++;
    if ({M_PSEL, tx_ready} !== 2'b01)
      $display("FAIL tx2_done got %b%b exp 01", M_PSEL, tx_ready);
    else pass_cnt++;
    @(negedge PCLK);
    tx_valid = 1'b0;
    @(negedge PCLK);
    chk_cnt++;
    if (M_PSEL !== 1'b0) $display("FAIL tx_holdoff got %b exp 0", M_PSEL);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PWDATA} !== {1'b1, 8'h3C})
      $display("FAIL tx3_after_hold got %b %h exp 1 3c", M_PSEL, M_PWDATA);
    else pass_cnt++;
    @(negedge PCLK);
    @(negedge PCLK);
    UART_TXRDY = 1'b0;
  endtask

  task automatic test_rx();
    bit ok;
    int n;
    UART_RXRDY = 1'b1;
    M_PRDATA = 8'hC3;
    rx_ready = 1'b0;
    wait_psel(8, ok);
    chk_cnt++;
    if (!ok || {M_PENABLE, M_PWRITE, M_PADDR} !== {2'b00, 5'h04})
      $display("FAIL rx_setup got %b %b%b %h exp 1 00 04",
               ok, M_PENABLE, M_PWRITE, M_PADDR);
    else pass_cnt++;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PENABLE, M_PADDR} !== {1'b1, 5'h04})
      $display("FAIL rx_access got %b %h exp 1 04", M_PENABLE, M_PADDR);
    else pass_cnt++;
    @(negedge PCLK);
    M_PRDATA = 8'h11;
    chk_cnt++;
    if ({M_PSEL, rx_valid, rx_data} !== {2'b01, 8'hC3})
      $display("FAIL rx_data got %b%b %h exp 01 c3", M_PSEL, rx_valid, rx_data);
    else pass_cnt++;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (M_PSEL) n++;
    end
    chk_cnt++;
    if (n !== 0) $display("FAIL rx_blocked got %0d exp 0", n);
    else pass_cnt++;
    chk_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hC3})
      $display("FAIL rx_held got %b %h exp 1 c3", rx_valid, rx_data);
    else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    chk_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL rx_consume got %b exp 0", rx_valid);
    else pass_cnt++;
    wait_psel(8, ok);
    chk_cnt++;
    if (!ok || M_PADDR !== 5'h04)
      $display("FAIL rx2_setup got %b %h exp 1 04", ok, M_PADDR);
    else pass_cnt++;
    @(negedge PCLK);
    @(negedge PCLK);
    UART_RXRDY = 1'b0;
    chk_cnt++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11})
      $display("FAIL rx2_data got %b %h exp 1 11", rx_valid, rx_data);
    else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    bit ok;
    int k;
    logic [4:0] got [6];
    logic [4:0] exp [6];
    exp = '{5'h04, 5'h00, 5'h04, 5'h00, 5'h04, 5'h00};
    got = '{default: 5'h1F};
    do_reset();
    PRESET = 1'b0;
    wait_cfg(20, ok);
    chk_cnt++;
    if (!ok) $display("FAIL arb_cfg got busy exp idle");
    else pass_cnt++;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    rx_ready = 1'b1;
    M_PRDATA = 8'h5E;
    @(negedge PCLK);
    UART_TXRDY = 1'b1;
    UART_RXRDY = 1'b1;
    k = 0;
    for (int i = 0; i < 60 && k < 6; i++) begin
      @(negedge PCLK);
      if (M_PSEL && !M_PENABLE) begin
        got[k] = M_PADDR;
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      chk_cnt++;
      if (got[i] !== exp[i])
        $display("FAIL arb_order%0d got %h exp %h", i, got[i], exp[i]);
      else pass_cnt++;
    end
    tx_valid = 1'b0;
    UART_TXRDY = 1'b0;
    UART_RXRDY = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    PRESET = 1'b0;
    wait_cfg(20, ok);
    M_PREADY = 1'b0;
    UART_TXRDY = 1'b1;
    tx_data = 8'h99;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    wait_psel(5, ok);
    UART_TXRDY = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE) n++;
      else break;
    end
    chk_cnt++;
    if (n !== 255) $display("FAIL tmo_cycles got %0d exp 255", n);
    else pass_cnt++;
    chk_cnt++;
    if ({M_PSEL, apb_err, tx_ready} !== 3'b011)
      $display("FAIL tmo_abort got %b%b%b exp 011", M_PSEL, apb_err, tx_ready);
    else pass_cnt++;
    M_PREADY = 1'b1;
    cfg_baud = 13'h1ABC;
    cfg_mode = 3'b110;
    cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    chk_cnt++;
    if ({apb_err, cfg_busy} !== 2'b01)
      $display("FAIL tmo_clear got %b%b exp 01", apb_err, cfg_busy);
    else pass_cnt++;
    wait_psel(5, ok);
    chk_cnt++;
    if (!ok || {M_PADDR, M_PWDATA} !== {5'h08, 8'hBC})
      $display("FAIL tmo_ctrl1 got %b %h %h exp 1 08 bc", ok, M_PADDR, M_PWDATA);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    chk_cnt++;
    if ({M_PADDR, M_PWDATA} !== {5'h0C, 8'hD6})
      $display("FAIL tmo_ctrl2 got %h %h exp 0c d6", M_PADDR, M_PWDATA);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    chk_cnt++;
    if (cfg_busy !== 1'b0) $display("FAIL tmo_cfgdone got %b exp 0", cfg_busy);
    else pass_cnt++;
  endtask

  task automatic test_slverr();
    bit ok;
    M_PSLVERR = 1'b1;
    M_PRDATA = 8'hEE;
    UART_RXRDY = 1'b1;
    wait_psel(8, ok);
    chk_cnt++;
    if (!ok || M_PADDR !== 5'h04)
      $display("FAIL err_rd got %b %h exp 1 04", ok, M_PADDR);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    UART_RXRDY = 1'b0;
    M_PSLVERR = 1'b0;
    chk_cnt++;
    if ({M_PSEL, rx_valid, apb_err} !== 3'b001)
      $display("FAIL err_discard got %b%b%b exp 001", M_PSEL, rx_valid, apb_err);
    else pass_cnt++;
  endtask

  task automatic test_cfg_during_tx();
    bit ok;
    M_PREADY = 1'b0;
    UART_TXRDY = 1'b1;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    wait_psel(5, ok);
    UART_TXRDY = 1'b0;
    @(negedge PCLK);
    cfg_baud = 13'h0123;
    cfg_mode = 3'b011;
    cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, cfg_busy, M_PADDR, M_PWDATA} !== {3'b111, 5'h00, 8'h3C})
      $display("FAIL cfgtx_hold got %b%b%b %h %h exp 111 00 3c",
               M_PSEL, M_PENABLE, cfg_busy, M_PADDR, M_PWDATA);
    else pass_cnt++;
    repeat (3) @(negedge PCLK);
    chk_cnt++;
    if ({M_PENABLE, M_PADDR, M_PWDATA} !== {1'b1, 5'h00, 8'h3C})
      $display("FAIL cfgtx_stable got %b %h %h exp 1 00 3c",
               M_PENABLE, M_PADDR, M_PWDATA);
    else pass_cnt++;
    M_PREADY = 1'b1;
    @(negedge PCLK);
    chk_cnt++;
    if (M_PSEL !== 1'b0) $display("FAIL cfgtx_end got %b exp 0", M_PSEL);
    else pass_cnt++;
    wait_psel(5, ok);
    chk_cnt++;
    if (!ok || {M_PADDR, M_PWDATA} !== {5'h08, 8'h23})
      $display("FAIL cfgtx_ctrl1 got %b %h %h exp 1 08 23", ok, M_PADDR, M_PWDATA);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    chk_cnt++;
    if ({M_PADDR, M_PWDATA} !== {5'h0C, 8'h0B})
      $display("FAIL cfgtx_ctrl2 got %h %h exp 0c 0b", M_PADDR, M_PWDATA);
    else pass_cnt++;
    repeat (2) @(negedge PCLK);
    chk_cnt++;
    if ({cfg_busy, apb_err} !== 2'b00)
      $display("FAIL cfgtx_done got %b%b exp 00", cfg_busy, apb_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    M_PREADY = 1'b0;
    UART_TXRDY = 1'b1;
    tx_data = 8'h42;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    wait_psel(5, ok);
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE} !== 2'b11)
      $display("FAIL rstmid_acc got %b%b exp 11", M_PSEL, M_PENABLE);
    else pass_cnt++;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk_cnt++;
    if ({M_PSEL, M_PENABLE, tx_ready, cfg_busy} !== 4'b0001)
      $display("FAIL rstmid_drop got %b%b%b%b exp 0001",
               M_PSEL, M_PENABLE, tx_ready, cfg_busy);
    else pass_cnt++;
    PRESET = 1'b0;
    M_PREADY = 1'b1;
    UART_TXRDY = 1'b0;
    wait_cfg(20, ok);
    chk_cnt++;
    if (!ok || tx_ready !== 1'b1)
      $display("FAIL rstmid_recover got %b %b exp 1 1", ok, tx_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cfg_init();
    test_tx();
    test_rx();
    test_arbitration();
    test_timeout();
    test_slverr();
    test_cfg_during_tx();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
